// File: rtl/message_streamer_if.sv
// Byte stream carrying the key header and decrypted message to the sink.
interface message_streamer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/message_streamer.sv
// Streams the 3-byte secret key (optional) and then MSG_LEN bytes read from
// the decrypted RAM, one byte per valid/ready handshake. Each RAM byte takes
// FETCH (address settles) -> WAIT (RAM q valid, captured) -> SEND (held).
module message_streamer #(
  parameter int MSG_LEN  = 32,
  parameter int ADDR_W   = 5,
  parameter int SEND_KEY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       secret_key,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [7:0]        ram_read_data,
  message_streamer_if.master strm,
  output logic              busy,
  output logic              finish
);

  typedef enum logic [2:0] {IDLE, KEY, FETCH, WAIT, SEND, DONE} state_t;

  // Counter is one bit wider than the address so MSG_LEN == 2**ADDR_W
  // reaches its terminal compare without wrapping.
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(MSG_LEN-1);

  state_t            state_q, state_d;
  logic [23:0]       key_q, key_d;
  logic [1:0]        kidx_q, kidx_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic              vld_q, vld_d;
  logic [7:0]        key_nxt;
  logic              hs;

  assign hs = vld_q & strm.out_ready;

  // Key byte following the one currently on the bus (MSB first).
  always_comb begin
    case (kidx_q + 2'd1)
      2'd0:    key_nxt = key_q[23:16];
      2'd1:    key_nxt = key_q[15:8];
      default: key_nxt = key_q[7:0];
    endcase
  end

  // Next-state and output-register logic; dropping start aborts any active state.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    kidx_d  = kidx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d  = secret_key;
          kidx_d = 2'd0;
          cnt_d  = '0;
          if (SEND_KEY != 0) begin
            state_d = KEY;
            vld_d   = 1'b1;
            data_d  = secret_key[23:16];
          end else begin
            state_d = FETCH;
          end
        end
      end
      KEY: begin
        if (hs) begin
          if (kidx_q == 2'd2) begin
            vld_d   = 1'b0;
            cnt_d   = '0;
            state_d = FETCH;
          end else begin
            kidx_d = kidx_q + 2'd1;
            data_d = key_nxt;
          end
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        data_d  = ram_read_data;
        vld_d   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (hs) begin
          vld_d = 1'b0;
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!start && (state_q == KEY || state_q == FETCH ||
                   state_q == WAIT || state_q == SEND)) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      cnt_d   = '0;
      kidx_d  = 2'd0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      kidx_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      kidx_q  <= kidx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign ram_address    = cnt_q[ADDR_W-1:0];
  assign strm.out_data  = data_q;
  assign strm.out_valid = vld_q;
  assign busy           = (state_q != IDLE) && (state_q != DONE);
  assign finish         = (state_q == DONE);

endmodule

// File: tb/tb_message_streamer.sv
// Bench for message_streamer: one instance with the key header, one without,
// each backed by a registered RAM model and a scoreboard queue of bytes.
module tb_message_streamer;
  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start_a, start_b;
  logic [23:0]       key_a, key_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [7:0]        rd_a, rd_b;
  logic              busy_a, busy_b, fin_a, fin_b;

  message_streamer_if sa();
  message_streamer_if sb();

  message_streamer #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W), .SEND_KEY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .secret_key(key_a),
    .ram_address(addr_a), .ram_read_data(rd_a), .strm(sa),
    .busy(busy_a), .finish(fin_a));

  message_streamer #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W), .SEND_KEY(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .secret_key(key_b),
    .ram_address(addr_b), .ram_read_data(rd_b), .strm(sb),
    .busy(busy_b), .finish(fin_b));

  // RAM model: q registered one cycle after the address.
  logic [7:0] mem [MSG_LEN];
  initial for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'h61 + 8'(i);
  always @(posedge clk) begin
    rd_a <= mem[addr_a];
    rd_b <= mem[addr_b];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int hs_a = 0, hs_b = 0;
  int mode_a = 0;
  int cyc = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] e_a, e_b, stall_d_a;
  logic       stall_a = 1'b0;

  // Sink ready: 0 = always ready, 1 = 3-on/3-off with random stalls, else never.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (mode_a)
      0:       sa.out_ready = 1'b1;
      1:       sa.out_ready = (((cyc / 3) % 2) == 0) && ($urandom_range(0, 3) != 0);
      default: sa.out_ready = 1'b0;
    endcase
    sb.out_ready = 1'b1;
  end

  // Sink A: a handshake completes on the next rising edge when valid, ready
  // and start are all high here; stalled bytes must not move.
  always @(negedge clk) begin
    if (!reset && start_a && stall_a) begin
      n_tests++;
      if (sa.out_valid !== 1'b1 || sa.out_data !== stall_d_a) begin
        n_fail++;
        $display("FAIL stall_hold_a got v=%b d=%h want v=1 d=%h", sa.out_valid, sa.out_data, stall_d_a);
      end
    end
    stall_a   = !reset && start_a && sa.out_valid && !sa.out_ready;
    stall_d_a = sa.out_data;
    if (!reset && start_a && sa.out_valid && sa.out_ready) begin
      hs_a++;
      n_tests++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL stream_a got extra byte %h want none", sa.out_data);
      end else begin
        e_a = q_a.pop_front();
        if (sa.out_data !== e_a) begin
          n_fail++;
          $display("FAIL stream_a byte %0d got %h want %h", hs_a, sa.out_data, e_a);
        end
      end
    end
  end

  // Sink B (no key header, always ready).
  always @(negedge clk) begin
    if (!reset && start_b && sb.out_valid && sb.out_ready) begin
      hs_b++;
      n_tests++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL stream_b got extra byte %h want none", sb.out_data);
      end else begin
        e_b = q_b.pop_front();
        if (sb.out_data !== e_b) begin
          n_fail++;
          $display("FAIL stream_b byte %0d got %h want %h", hs_b, sb.out_data, e_b);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_a(input logic [23:0] k);
    q_a.push_back(k[23:16]);
    q_a.push_back(k[15:8]);
    q_a.push_back(k[7:0]);
    for (int i = 0; i < MSG_LEN; i++) q_a.push_back(mem[i]);
  endtask

  // Wait for finish on A; a timeout counts as a failure.
  task automatic wait_fin_a(input int bound, input string name);
    int n;
    n = 0;
    while (!fin_a && n < bound) begin tick(1); n++; end
    n_tests++;
    if (fin_a !== 1'b1) begin n_fail++; $display("FAIL %s_timeout got fin=%b want 1", name, fin_a); end
  endtask

  task automatic test_reset;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; key_a = '0; key_b = 24'h777777;
    sa.out_ready = 1'b0; sb.out_ready = 1'b0;
    tick(2);
    n_tests++; if (sa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", sa.out_valid); end
    n_tests++; if (sa.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h want 00", sa.out_data); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy_a); end
    n_tests++; if (fin_a !== 1'b0) begin n_fail++; $display("FAIL rst_finish got %b want 0", fin_a); end
    n_tests++; if (addr_a !== '0) begin n_fail++; $display("FAIL rst_addr got %0d want 0", addr_a); end
    n_tests++; if (sb.out_valid !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL rst_b got v=%b busy=%b want 0 0", sb.out_valid, busy_b); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid_send;
    int n;
    mode_a = 0; key_a = 24'h123456; q_a.delete(); push_a(key_a);
    start_a = 1'b1;
    n = 0; while (hs_a < 4 && n < 200) begin tick(1); n++; end
    mode_a = 2;
    n = 0; while (!(sa.out_valid && !sa.out_ready) && n < 50) begin tick(1); n++; end
    n_tests++; if (n >= 50 || addr_a !== 5'd1) begin n_fail++; $display("FAIL midsend_reach got addr=%0d want SEND stall at addr 1", addr_a); end
    reset = 1'b1;
    #1;
    n_tests++; if (sa.out_valid !== 1'b0 || busy_a !== 1'b0 || fin_a !== 1'b0 || addr_a !== '0) begin
      n_fail++; $display("FAIL midsend_async got v=%b busy=%b fin=%b addr=%0d want 0 0 0 0", sa.out_valid, busy_a, fin_a, addr_a);
    end
    tick(1); start_a = 1'b0; tick(1); reset = 1'b0; tick(2);
    n_tests++; if (busy_a !== 1'b0 || sa.out_valid !== 1'b0 || fin_a !== 1'b0) begin
      n_fail++; $display("FAIL midsend_idle got busy=%b v=%b fin=%b want 0 0 0", busy_a, sa.out_valid, fin_a);
    end
    q_a.delete();
  endtask

  task automatic test_stream;
    int h0;
    mode_a = 0; key_a = 24'h0003FF; q_a.delete(); push_a(key_a);
    h0 = hs_a; start_a = 1'b1;
    wait_fin_a(1000, "stream");
    n_tests++; if (hs_a - h0 !== 35) begin n_fail++; $display("FAIL stream_count got %0d want 35", hs_a - h0); end
    n_tests++; if (q_a.size() !== 0) begin n_fail++; $display("FAIL stream_left got %0d want 0", q_a.size()); end
    // start still high: DONE must hold with no further bytes
    h0 = hs_a;
    tick(20);
    n_tests++; if (fin_a !== 1'b1 || busy_a !== 1'b0 || sa.out_valid !== 1'b0 || hs_a !== h0) begin
      n_fail++; $display("FAIL done_hold got fin=%b busy=%b v=%b bytes=%0d want 1 0 0 0", fin_a, busy_a, sa.out_valid, hs_a - h0);
    end
    // second transfer with a new key under a stalling sink
    start_a = 1'b0; key_a = 24'hABCDEF; push_a(24'hABCDEF);
    tick(1);
    start_a = 1'b1; mode_a = 1; h0 = hs_a;
    tick(2);
    key_a = 24'h111111;
    wait_fin_a(4000, "stall");
    n_tests++; if (hs_a - h0 !== 35) begin n_fail++; $display("FAIL stall_count got %0d want 35", hs_a - h0); end
    n_tests++; if (q_a.size() !== 0) begin n_fail++; $display("FAIL stall_left got %0d want 0", q_a.size()); end
    mode_a = 0;
  endtask

  task automatic test_no_key;
    int n, run, h0;
    logic [ADDR_W-1:0] prev;
    q_b.delete();
    for (int i = 0; i < MSG_LEN; i++) q_b.push_back(mem[i]);
    h0 = hs_b; prev = addr_b; run = 1; n = 0;
    start_b = 1'b1;
    while (!fin_b && n < 500) begin
      tick(1); n++;
      if (addr_b !== prev) begin
        n_tests++;
        if (addr_b !== prev + 5'd1 || run < 2) begin
          n_fail++; $display("FAIL addr_seq got %0d after %0d held %0d want %0d held>=2", addr_b, prev, run, prev + 5'd1);
        end
        prev = addr_b; run = 1;
      end else run++;
    end
    n_tests++; if (n < 96 || n > 98) begin n_fail++; $display("FAIL nokey_cycles got %0d want 97+-1", n); end
    n_tests++; if (hs_b - h0 !== 32) begin n_fail++; $display("FAIL nokey_count got %0d want 32", hs_b - h0); end
    n_tests++; if (q_b.size() !== 0 || prev !== 5'd31) begin n_fail++; $display("FAIL nokey_end got left=%0d addr=%0d want 0 31", q_b.size(), prev); end
    start_b = 1'b0;
    tick(1);
  endtask

  task automatic test_abort;
    int n, h0;
    start_a = 1'b0; tick(1);
    mode_a = 0; q_a.delete(); key_a = 24'h5A5A5A; push_a(key_a);
    h0 = hs_a; start_a = 1'b1;
    n = 0; while (hs_a - h0 < 13 && n < 300) begin tick(1); n++; end
    mode_a = 2;
    n = 0; while (!(sa.out_valid && !sa.out_ready) && n < 50) begin tick(1); n++; end
    n_tests++; if (n >= 50) begin n_fail++; $display("FAIL abort_reach got v=%b r=%b want stalled byte", sa.out_valid, sa.out_ready); end
    start_a = 1'b0;
    tick(1);
    n_tests++; if (sa.out_valid !== 1'b0 || busy_a !== 1'b0 || addr_a !== '0 || fin_a !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got v=%b busy=%b addr=%0d fin=%b want 0 0 0 0", sa.out_valid, busy_a, addr_a, fin_a);
    end
    q_a.delete(); key_a = 24'hC0FFEE; push_a(key_a);
    mode_a = 0; h0 = hs_a; start_a = 1'b1;
    wait_fin_a(1000, "restart");
    n_tests++; if (hs_a - h0 !== 35 || q_a.size() !== 0) begin
      n_fail++; $display("FAIL restart_count got %0d left=%0d want 35 0", hs_a - h0, q_a.size());
    end
    start_a = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_reset_mid_send();
    test_stream();
    test_no_key();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
